// File: rtl/tank_move_check.sv
// Tank move legality check: proposes a new position, scans the 3x3 barrier tile
// window under it through the map read port, and resolves the move in fixed latency.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  S_IDLE  | waiting for start; last result held on the outputs
//  S_FETCH | tiles 0..8 addressed one per cycle, previous tile evaluated
//  S_DRAIN | last tile's map data evaluated, no read issued
//  S_DONE  | done strobe high for one cycle, result registered
module tank_move_check #(
   parameter int TANK_SIZE = 16,
   parameter int TILE_SIZE = 8,
   parameter int MAP_W     = 26,
   parameter int MAP_H     = 26,
   parameter int FIELD_MAX = 192
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       start,
   input  logic [8:0] Tank_X,
   input  logic [8:0] Tank_Y,
   input  logic [1:0] Dir,
   input  logic [1:0] Step,
   output logic [9:0] map_addr,
   output logic       map_rd_en,
   input  logic [2:0] map_data,
   output logic       busy,
   output logic       done,
   output logic       blocked,
   output logic [8:0] Tank_X_out,
   output logic [8:0] Tank_Y_out
);

   localparam int                SH     = $clog2(TILE_SIZE);
   localparam logic signed [15:0] TANK_S = 16'(TANK_SIZE);
   localparam logic signed [15:0] TILE_S = 16'(TILE_SIZE);
   localparam logic [9:0]        FMAX   = 10'(FIELD_MAX);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

   state_t            state_q, state_d;
   logic [3:0]        k_q, k_d;
   logic signed [9:0] nx_q, nx_d, ny_q, ny_d;
   logic [8:0]        cx_q, cx_d, cy_q, cy_d;
   logic              oob_q, oob_d, coll_q, coll_d;
   logic [9:0]        addr_q, addr_d;
   logic              rd_en_q, rd_en_d;
   logic [7:0]        col_q, col_d, row_q, row_d;
   logic [7:0]        ecol_q, ecol_d, erow_q, erow_d;
   logic              ev_q, ev_d;
   logic              busy_q, busy_d, done_q, done_d, blocked_q, blocked_d;
   logic [8:0]        xo_q, xo_d, yo_q, yo_d;

   logic signed [9:0]  px, py;
   logic [9:0]         step_w, base_x, base_y;
   logic [3:0]         nk;
   logic               gen, in_map, hit, blk;
   logic [7:0]         col_n, row_n;
   logic signed [15:0] tx_s, ty_s, nx_s, ny_s;

   always_comb begin
      step_w = {8'd0, Step};
      px = {1'b0, Tank_X};
      py = {1'b0, Tank_Y};
      case (Dir)
         2'd0:    py = {1'b0, Tank_Y} - step_w;
         2'd1:    px = {1'b0, Tank_X} + step_w;
         2'd2:    py = {1'b0, Tank_Y} + step_w;
         default: px = {1'b0, Tank_X} - step_w;
      endcase

      // tile under evaluation was addressed last cycle; its data is on map_data now
      tx_s = $signed(16'(ecol_q)) * TILE_S;
      ty_s = $signed(16'(erow_q)) * TILE_S;
      nx_s = 16'(nx_q);
      ny_s = 16'(ny_q);
      hit  = ev_q && (map_data < 3'd3) &&
             (tx_s < nx_s + TANK_S) && (tx_s + TILE_S > nx_s) &&
             (ty_s < ny_s + TANK_S) && (ty_s + TILE_S > ny_s);

      state_d   = state_q;
      k_d       = k_q;
      nx_d      = nx_q;
      ny_d      = ny_q;
      cx_d      = cx_q;
      cy_d      = cy_q;
      oob_d     = oob_q;
      coll_d    = coll_q | hit;
      ecol_d    = col_q;
      erow_d    = row_q;
      ev_d      = 1'b0;
      busy_d    = busy_q;
      done_d    = 1'b0;
      blocked_d = blocked_q;
      xo_d      = xo_q;
      yo_d      = yo_q;
      blk       = 1'b0;
      gen       = 1'b0;
      base_x    = nx_q;
      base_y    = ny_q;
      nk        = 4'd0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_FETCH;
               nx_d    = px;
               ny_d    = py;
               cx_d    = Tank_X;
               cy_d    = Tank_Y;
               oob_d   = px[9] | py[9] | (px > FMAX) | (py > FMAX);
               coll_d  = 1'b0;
               k_d     = 4'd0;
               busy_d  = 1'b1;
               gen     = 1'b1;
               base_x  = px;
               base_y  = py;
            end
         end
         S_FETCH: begin
            ev_d = rd_en_q;
            if (k_q == 4'd8) begin
               state_d = S_DRAIN;
            end else begin
               k_d = k_q + 4'd1;
               nk  = k_q + 4'd1;
               gen = 1'b1;
            end
         end
         S_DRAIN: begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            blk       = oob_q | coll_q | hit;
            blocked_d = blk;
            xo_d      = blk ? cx_q : nx_q[8:0];
            yo_d      = blk ? cy_q : ny_q[8:0];
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase

      col_n   = 8'(base_x >> SH) + 8'(nk % 4'd3);
      row_n   = 8'(base_y >> SH) + 8'(nk / 4'd3);
      in_map  = (col_n < 8'(MAP_W)) && (row_n < 8'(MAP_H));
      rd_en_d = gen && in_map;
      addr_d  = rd_en_d ? 10'(16'(row_n) * 16'(MAP_W) + 16'(col_n)) : 10'd0;
      col_d   = gen ? col_n : col_q;
      row_d   = gen ? row_n : row_q;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q   <= S_IDLE;
         k_q       <= '0;
         nx_q      <= '0;
         ny_q      <= '0;
         cx_q      <= '0;
         cy_q      <= '0;
         oob_q     <= 1'b0;
         coll_q    <= 1'b0;
         addr_q    <= '0;
         rd_en_q   <= 1'b0;
         col_q     <= '0;
         row_q     <= '0;
         ecol_q    <= '0;
         erow_q    <= '0;
         ev_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         blocked_q <= 1'b0;
         xo_q      <= '0;
         yo_q      <= '0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         nx_q      <= nx_d;
         ny_q      <= ny_d;
         cx_q      <= cx_d;
         cy_q      <= cy_d;
         oob_q     <= oob_d;
         coll_q    <= coll_d;
         addr_q    <= addr_d;
         rd_en_q   <= rd_en_d;
         col_q     <= col_d;
         row_q     <= row_d;
         ecol_q    <= ecol_d;
         erow_q    <= erow_d;
         ev_q      <= ev_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         blocked_q <= blocked_d;
         xo_q      <= xo_d;
         yo_q      <= yo_d;
      end
   end

   assign map_addr   = addr_q;
   assign map_rd_en  = rd_en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign blocked    = blocked_q;
   assign Tank_X_out = xo_q;
   assign Tank_Y_out = yo_q;

endmodule

// File: tb/tb_tank_move_check.sv
// Bench for tank_move_check: a behavioural map memory plus a reference model that
// derives reads, latency and the move result directly from the movement rules.
module tb_tank_move_check;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic       start = 1'b0;
   logic [8:0] Tank_X = '0, Tank_Y = '0;
   logic [1:0] Dir = '0, Step = '0;
   logic [9:0] map_addr;
   logic       map_rd_en;
   logic [2:0] map_data;
   logic       busy, done, blocked;
   logic [8:0] Tank_X_out, Tank_Y_out;

   int mem [676];
   int tests = 0;
   int fails = 0;
   int m_bl, m_x, m_y;
   int m_rd[$];

   tank_move_check dut (
      .Clk(Clk), .Reset_n(Reset_n), .start(start),
      .Tank_X(Tank_X), .Tank_Y(Tank_Y), .Dir(Dir), .Step(Step),
      .map_addr(map_addr), .map_rd_en(map_rd_en), .map_data(map_data),
      .busy(busy), .done(done), .blocked(blocked),
      .Tank_X_out(Tank_X_out), .Tank_Y_out(Tank_Y_out)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk)
      if (map_rd_en) map_data <= 3'(mem[map_addr]);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"},  32'(busy), 0);
      chk({tag, "_done"},  32'(done), 0);
      chk({tag, "_blk"},   32'(blocked), 0);
      chk({tag, "_rden"},  32'(map_rd_en), 0);
      chk({tag, "_addr"},  32'(map_addr), 0);
      chk({tag, "_xo"},    32'(Tank_X_out), 0);
      chk({tag, "_yo"},    32'(Tank_Y_out), 0);
   endtask

   task automatic fill_map(input bit rnd);
      for (int i = 0; i < 676; i++)
         if (!rnd) mem[i] = 3;
         else mem[i] = ($urandom_range(0, 9) < 2) ? int'($urandom_range(0, 2))
                                                   : int'($urandom_range(3, 7));
   endtask

   // Reference: expected reads tagged as cycle*1024+addr, plus the resolved result.
   task automatic model(input int x, input int y, input int d, input int s);
      int nx, ny, col0, row0, col, row, a, tx, ty;
      bit oob, coll;
      nx = x; ny = y;
      case (d)
         0: ny = y - s;
         1: nx = x + s;
         2: ny = y + s;
         default: nx = x - s;
      endcase
      oob  = (nx < 0) || (ny < 0) || (nx > 192) || (ny > 192);
      col0 = (nx & 1023) >> 3;
      row0 = (ny & 1023) >> 3;
      coll = 0;
      m_rd.delete();
      for (int k = 0; k < 9; k++) begin
         col = col0 + k % 3;
         row = row0 + k / 3;
         if (col < 26 && row < 26) begin
            a = row * 26 + col;
            m_rd.push_back((k + 1) * 1024 + a);
            tx = col * 8;
            ty = row * 8;
            if (mem[a] < 3 && tx < nx + 16 && tx + 8 > nx && ty < ny + 16 && ty + 8 > ny)
               coll = 1;
         end
      end
      m_bl = int'(oob || coll);
      m_x  = m_bl ? x : nx;
      m_y  = m_bl ? y : ny;
   endtask

   task automatic run_move(input string tag, input int x, input int y, input int d,
                           input int s, input bit poke);
      int got_rd[$];
      int done_cyc, done_n, nz_addr, g_bl, g_x, g_y;
      model(x, y, d, s);
      @(negedge Clk);
      Tank_X = 9'(x); Tank_Y = 9'(y); Dir = 2'(d); Step = 2'(s);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      done_cyc = 0; done_n = 0; nz_addr = 0; g_bl = 0; g_x = 0; g_y = 0;
      for (int c = 1; c <= 14; c++) begin
         if (c == 1) chk({tag, "_busy_c1"}, 32'(busy), 1);
         if (poke && c == 4) begin
            start = 1'b1; Tank_X = 9'd10; Tank_Y = 9'd20; Dir = 2'd3; Step = 2'd1;
         end
         if (poke && c == 5) start = 1'b0;
         if (map_rd_en) got_rd.push_back(c * 1024 + int'(map_addr));
         else if (map_addr != 0) nz_addr++;
         if (done) begin
            done_n++;
            if (done_cyc == 0) begin
               done_cyc = c;
               g_bl = int'(blocked); g_x = int'(Tank_X_out); g_y = int'(Tank_Y_out);
            end
         end
         @(negedge Clk);
      end
      chk({tag, "_done_cyc"}, 32'(done_cyc), 11);
      chk({tag, "_done_cnt"}, 32'(done_n), 1);
      chk({tag, "_blocked"}, 32'(g_bl), 32'(m_bl));
      chk({tag, "_x_out"}, 32'(g_x), 32'(m_x));
      chk({tag, "_y_out"}, 32'(g_y), 32'(m_y));
      chk({tag, "_hold_x"}, 32'(Tank_X_out), 32'(m_x));
      chk({tag, "_busy_end"}, 32'(busy), 0);
      chk({tag, "_addr_idle0"}, 32'(nz_addr), 0);
      chk({tag, "_nreads"}, 32'(got_rd.size()), 32'(m_rd.size()));
      for (int i = 0; i < m_rd.size() && i < got_rd.size(); i++)
         chk({tag, "_read"}, 32'(got_rd[i]), 32'(m_rd[i]));
   endtask

   initial begin
      int dn;
      fill_map(0);
      repeat (3) @(negedge Clk);
      chk_zero("reset");
      Reset_n = 1'b1;

      run_move("free", 64, 64, 1, 2, 0);
      mem[218] = 0;
      run_move("wall", 64, 64, 1, 1, 0);
      run_move("aligned", 62, 64, 1, 2, 0);
      run_move("step0_in_wall", 70, 60, 2, 0, 0);
      mem[218] = 3;
      run_move("oob_right", 192, 0, 1, 3, 0);
      run_move("oob_left", 1, 50, 3, 2, 0);
      run_move("oob_up", 40, 1, 0, 3, 0);
      run_move("edge_down", 190, 190, 2, 2, 0);
      mem[25 * 26 + 25] = 1;
      run_move("edge_wall", 190, 190, 2, 2, 0);
      mem[25 * 26 + 25] = 3;
      run_move("start_ignored", 64, 64, 1, 2, 1);

      // asynchronous reset mid-scan clears outputs before the next edge
      @(negedge Clk);
      Tank_X = 9'd64; Tank_Y = 9'd64; Dir = 2'd1; Step = 2'd2; start = 1'b1;
      @(negedge Clk); start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1 chk_zero("async_rst");
      @(negedge Clk); Reset_n = 1'b1;
      run_move("after_rst", 100, 100, 0, 3, 0);

      // start poke in cycle 4, reset in cycle 5: evaluation dropped, no done
      @(negedge Clk);
      Tank_X = 9'd64; Tank_Y = 9'd64; Dir = 2'd1; Step = 2'd2; start = 1'b1;
      @(negedge Clk); start = 1'b0;
      repeat (3) @(negedge Clk);
      start = 1'b1; Tank_X = 9'd8;
      @(negedge Clk); start = 1'b0;
      #2 Reset_n = 1'b0;
      #1 chk("abort_busy", 32'(busy), 0);
      @(negedge Clk); Reset_n = 1'b1;
      dn = 0;
      repeat (15) begin
         @(negedge Clk);
         if (done) dn++;
      end
      chk("abort_no_done", 32'(dn), 0);
      chk("abort_idle", 32'(busy), 0);
      run_move("after_abort", 64, 64, 1, 2, 0);

      for (int i = 0; i < 40; i++) begin
         if (i % 5 == 0) fill_map(1);
         run_move("rand", int'($urandom_range(0, 195)), int'($urandom_range(0, 195)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
